// File: rtl/mode_arbiter_pkg.sv
// Purpose : shared constants, state encoding and display helper for the front-panel arbiter.
// Latency : n/a (package only).
// Backpressure : n/a.
package mode_arbiter_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;  // segments are active-low, all ones = dark digit
  localparam int DIGITS = 6;
  localparam int SEG_W  = 8 * DIGITS;
  localparam int BTN_W  = 6;

  // Bit positions inside a 6-bit button vector
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ENTER = 4;
  localparam int BTN_ESC   = 5;

  // Function block indices
  localparam int MODE_CLOCK = 0;
  localparam int MODE_SW    = 1;
  localparam int MODE_TIMER = 2;
  localparam int MODE_ALARM = 3;

  typedef enum logic {
    ST_BLANK  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Dark out every digit flagged in blk while the blink phase is in its off half.
  function automatic logic [SEG_W-1:0] apply_blink(input logic [SEG_W-1:0] disp,
                                                    input logic [DIGITS-1:0] blk,
                                                    input logic              phase);
    logic [SEG_W-1:0] s;
    s = disp;
    for (int d = 0; d < DIGITS; d++) begin
      if (blk[d] && !phase) s[8*d +: 8] = SEG_BLANK;
    end
    return s;
  endfunction

endpackage

// File: rtl/mode_arbiter_if.sv
// Purpose : panel-side bundle between the arbiter and the function blocks.
// Latency : n/a (wires only); seg/cur_mode are registered inside the arbiter.
// Backpressure : none; mode switches are gated by norm_in of the active block.
// Signals: mode_btn, btn_in[6], disp_in[48*N], blk_in[6*N], norm_in[N] (into arbiter);
//          mode_en[N], btn_out[6*N], seg[48], cur_mode (out of arbiter).
interface mode_arbiter_if
  import mode_arbiter_pkg::*;
#(
  parameter int N_MODES = 4
);
  localparam int MW = (N_MODES > 1) ? $clog2(N_MODES) : 1;

  logic                       mode_btn;
  logic [BTN_W-1:0]           btn_in;
  logic [SEG_W*N_MODES-1:0]   disp_in;
  logic [DIGITS*N_MODES-1:0]  blk_in;
  logic [N_MODES-1:0]         norm_in;
  logic [N_MODES-1:0]         mode_en;
  logic [BTN_W*N_MODES-1:0]   btn_out;
  logic [SEG_W-1:0]           seg;
  logic [MW-1:0]              cur_mode;

  // master = panel / function-block side, slave = the arbiter
  modport master (
    output mode_btn, btn_in, disp_in, blk_in, norm_in,
    input  mode_en, btn_out, seg, cur_mode
  );

  modport slave (
    input  mode_btn, btn_in, disp_in, blk_in, norm_in,
    output mode_en, btn_out, seg, cur_mode
  );

endinterface

// File: rtl/mode_arbiter_blink_gen.sv
// Purpose : square-wave blink phase, HALF cycles per half-period; restart forces phase=1.
// Latency : phase is a register; restart takes effect on the next cycle.
// Backpressure : none.
// Ports: clk, rst_n (sync, active-low), restart (in), phase (out).
module mode_arbiter_blink_gen #(
  parameter int HALF = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic phase
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mode_arbiter.sv
// Purpose : time-multiplexes buttons, segment bus and blink mask among N_MODES function blocks.
// Latency : seg is 1 cycle behind its inputs; mode_en/btn_out follow state and btn_in combinationally.
// Backpressure : a mode-button edge is honoured only when the active block reports norm; else dropped.
// Ports: clk, rst_n (sync, active-low), bus (mode_arbiter_if.slave).
module mode_arbiter
  import mode_arbiter_pkg::*;
#(
  parameter int N_MODES    = 4,
  parameter int BLANK_CYC  = 16,
  parameter int BLINK_HALF = 500000
) (
  input  logic          clk,
  input  logic          rst_n,
  mode_arbiter_if.slave bus
);

  localparam int MW = (N_MODES > 1) ? $clog2(N_MODES) : 1;
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC - 1);
  localparam logic [MW-1:0] LAST_MODE  = MW'(N_MODES - 1);

  state_t           state, state_nxt;
  logic [BW-1:0]    blank_cnt, blank_nxt;
  logic [MW-1:0]    cur, cur_nxt;
  logic             mode_btn_q;
  logic [BTN_W-1:0] btn_mask;
  logic [SEG_W-1:0] seg_q, seg_nxt;
  logic             blink_ph;
  logic             mode_edge;
  logic             accept;
  logic             enter_active;

  assign mode_edge = bus.mode_btn & ~mode_btn_q;

  // Next-state: BLANK counts down the dead time, ACTIVE waits for a qualified edge.
  always_comb begin
    state_nxt    = state;
    blank_nxt    = blank_cnt;
    cur_nxt      = cur;
    accept       = 1'b0;
    enter_active = 1'b0;
    case (state)
      ST_BLANK: begin
        if (blank_cnt == '0) begin
          state_nxt    = ST_ACTIVE;
          enter_active = 1'b1;
        end else begin
          blank_nxt = blank_cnt - 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Edge arriving while the block is mid-edit is dropped, not queued.
        if (mode_edge && bus.norm_in[cur]) begin
          accept    = 1'b1;
          state_nxt = ST_BLANK;
          blank_nxt = BLANK_LOAD;
          cur_nxt   = (cur == LAST_MODE) ? '0 : cur + 1'b1;
        end
      end
      default: state_nxt = ST_BLANK;
    endcase
  end

  // Enables and button routing; the accepting cycle routes nothing so the
  // outgoing block never sees a button together with its own deselection.
  always_comb begin
    bus.mode_en = '0;
    bus.btn_out = '0;
    if (state == ST_ACTIVE) begin
      bus.mode_en[cur] = 1'b1;
      if (!accept) bus.btn_out[BTN_W*int'(cur) +: BTN_W] = bus.btn_in & ~btn_mask;
    end
  end

  always_comb begin
    seg_nxt = {DIGITS{SEG_BLANK}};
    if (state == ST_ACTIVE) begin
      seg_nxt = apply_blink(bus.disp_in[SEG_W*int'(cur) +: SEG_W],
                            bus.blk_in[DIGITS*int'(cur) +: DIGITS], blink_ph);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_BLANK;
      blank_cnt  <= BLANK_LOAD;
      cur        <= MW'(MODE_CLOCK);
      mode_btn_q <= 1'b0;
      btn_mask   <= '1;
      seg_q      <= {DIGITS{SEG_BLANK}};
    end else begin
      state      <= state_nxt;
      blank_cnt  <= blank_nxt;
      cur        <= cur_nxt;
      mode_btn_q <= bus.mode_btn;
      seg_q      <= seg_nxt;
      // Mask every button on entry; a bit unmasks only once seen released,
      // so a press held across the switch never reaches the new block.
      if (enter_active) btn_mask <= '1;
      else if (state == ST_ACTIVE) btn_mask <= btn_mask & bus.btn_in;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.cur_mode = cur;

  mode_arbiter_blink_gen #(
    .HALF (BLINK_HALF)
  ) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (enter_active),
    .phase   (blink_ph)
  );

endmodule

// File: tb/tb_mode_arbiter.sv
// Purpose : self-checking bench for mode_arbiter: directed scenarios plus randomized run vs a model.
// Latency : model predicts seg one cycle after inputs, mode_en/btn_out in the same cycle.
// Backpressure : mode_btn edges are dropped while the active block is not in norm.
module tb_mode_arbiter;

  localparam int N     = 4;
  localparam int BLANK = 16;
  localparam int HALF  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mode_arbiter_if #(.N_MODES(N)) bus ();

  mode_arbiter #(
    .N_MODES    (N),
    .BLANK_CYC  (BLANK),
    .BLINK_HALF (HALF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks: which mode is selected, whether it is live, how long it has been
  // dark or live, which buttons are still held since the mode came up.
  bit          m_valid  = 1'b0;
  bit          m_active;
  int          m_blank;     // dark cycles already spent
  int          m_cur;
  int          m_act;       // live cycles since mode came up
  logic [5:0]  m_held;      // buttons pressed at mode entry and not yet released
  logic        m_prev;
  logic [47:0] m_seg;

  function automatic bit accept_now();
    return m_active && bus.mode_btn && !m_prev && bus.norm_in[m_cur];
  endfunction

  function automatic logic [47:0] shown();
    logic [47:0] s;
    s = bus.disp_in[48*m_cur +: 48];
    // off half of the blink: live cycles HALF..2*HALF-1, 3*HALF.., ...
    if (((m_act / HALF) % 2) == 1) begin
      for (int d = 0; d < 6; d++)
        if (bus.blk_in[6*m_cur + d]) s[8*d +: 8] = 8'hFF;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid  <= 1'b1;
      m_active <= 1'b0;
      m_blank  <= 0;
      m_cur    <= 0;
      m_act    <= 0;
      m_held   <= 6'h3F;
      m_prev   <= 1'b0;
      m_seg    <= '1;
    end else if (m_valid) begin
      m_prev <= bus.mode_btn;
      m_seg  <= m_active ? shown() : '1;
      if (m_active) begin
        if (accept_now()) begin
          m_active <= 1'b0;
          m_blank  <= 0;
          m_cur    <= (m_cur + 1) % N;
        end else begin
          m_act  <= m_act + 1;
          m_held <= m_held & bus.btn_in;
        end
      end else if (m_blank == BLANK - 1) begin
        m_active <= 1'b1;
        m_act    <= 0;
        m_held   <= 6'h3F;
      end else begin
        m_blank <= m_blank + 1;
      end
    end
  end

  // Compare process: every cycle, after the driver has updated inputs.
  always begin
    logic [N-1:0]   e_en;
    logic [6*N-1:0] e_btn;
    @(negedge clk);
    #2;
    if (m_valid) begin
      e_en  = '0;
      e_btn = '0;
      if (m_active) begin
        e_en[m_cur] = 1'b1;
        if (!accept_now()) e_btn[6*m_cur +: 6] = bus.btn_in & ~m_held;
      end
      check("mdl_mode_en", 64'(bus.mode_en), 64'(e_en));
      check("mdl_cur_mode", 64'(bus.cur_mode), 64'(m_cur));
      check("mdl_btn_out", 64'(bus.btn_out), 64'(e_btn));
      check("mdl_seg", 64'(bus.seg), 64'(m_seg));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rand_disp();
    for (int i = 0; i < 6; i++) bus.disp_in[32*i +: 32] = $urandom();
  endtask

  task automatic wait_active();
    for (int n = 0; n < 40; n++) begin
      tick();
      #3;
      if (bus.mode_en != '0) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_active timeout actual=mode_en=0 required=nonzero t=%0t", $time);
  endtask

  task automatic switch_once();
    tick();
    bus.mode_btn = 1'b1;
    tick();
    bus.mode_btn = 1'b0;
    wait_active();
  endtask

  logic [47:0] disp1;

  initial begin
    bus.mode_btn = 1'b0;
    bus.btn_in   = '0;
    bus.norm_in  = 4'hF;
    bus.blk_in   = '0;
    rand_disp();
    disp1 = bus.disp_in[48 +: 48];

    // 1: reset for 3 edges, release, 16 dark cycles then mode 0
    rst_n = 1'b0;
    repeat (3) tick();
    tick();
    rst_n = 1'b1;
    #3;
    check("rst_seg", 64'(bus.seg), 64'h0000_FFFF_FFFF_FFFF);
    check("rst_mode_en", 64'(bus.mode_en), 64'h0);
    check("rst_btn_out", 64'(bus.btn_out), 64'h0);
    for (int k = 2; k <= 16; k++) begin
      tick();
      #3;
      check("blank_mode_en", 64'(bus.mode_en), 64'h0);
      check("blank_seg", 64'(bus.seg), 64'h0000_FFFF_FFFF_FFFF);
    end
    tick();
    #3;
    check("c17_mode_en", 64'(bus.mode_en), 64'h1);
    check("c17_cur_mode", 64'(bus.cur_mode), 64'h0);

    // 2: mode 0 -> 1; a button in the accepting cycle is not routed
    tick();
    bus.mode_btn = 1'b1;
    bus.btn_in   = 6'h05;
    #3;
    check("acc_btn_zero", 64'(bus.btn_out), 64'h0);
    tick();
    bus.mode_btn = 1'b0;
    bus.btn_in   = '0;
    #3;
    check("sw_mode_en_off", 64'(bus.mode_en), 64'h0);
    check("sw_cur_mode", 64'(bus.cur_mode), 64'h1);
    repeat (15) tick();
    #3;
    check("sw_still_dark", 64'(bus.mode_en), 64'h0);
    tick();
    #3;
    check("sw_mode_en_on", 64'(bus.mode_en), 64'h2);
    tick();
    #3;
    check("sw_seg_mode1", 64'(bus.seg), 64'(disp1));

    // 3: reach mode 3, then wrap to 0
    switch_once();
    switch_once();
    check("m3_cur", 64'(bus.cur_mode), 64'h3);
    check("m3_mode_en", 64'(bus.mode_en), 64'h8);
    tick();
    bus.mode_btn = 1'b1;
    tick();
    bus.mode_btn = 1'b0;
    #3;
    check("wrap_cur", 64'(bus.cur_mode), 64'h0);
    repeat (16) tick();
    #3;
    check("wrap_mode_en", 64'(bus.mode_en), 64'h1);
    switch_once();

    // 4: mode 1 not in norm -> edge dropped, and not remembered
    bus.norm_in = 4'b1101;
    tick();
    bus.mode_btn = 1'b1;
    tick();
    bus.mode_btn = 1'b0;
    #3;
    check("nonorm_cur", 64'(bus.cur_mode), 64'h1);
    check("nonorm_mode_en", 64'(bus.mode_en), 64'h2);
    repeat (3) tick();
    tick();
    bus.norm_in = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      #3;
      check("late_norm_cur", 64'(bus.cur_mode), 64'h1);
    end

    // 5: enter held through 1 -> 2
    tick();
    bus.mode_btn = 1'b1;
    bus.btn_in   = 6'b010000;
    #3;
    check("hold_acc_btn", 64'(bus.btn_out), 64'h0);
    tick();
    bus.mode_btn = 1'b0;
    #3;
    check("hold_blank_btn", 64'(bus.btn_out), 64'h0);
    for (int k = 1; k <= 19; k++) begin
      tick();
      #3;
      check("hold_btn_masked", 64'(bus.btn_out), 64'h0);
    end
    check("hold_mode_en", 64'(bus.mode_en), 64'h4);
    tick();
    bus.btn_in = '0;
    #3;
    check("hold_release", 64'(bus.btn_out), 64'h0);
    tick();
    bus.btn_in = 6'b010000;
    #3;
    check("hold_repress", 64'(bus.btn_out), 64'h01_0000);
    tick();
    bus.btn_in = '0;

    // 6: blink on mode 3, digits 0 and 1 flagged, all digits 00
    bus.disp_in = '0;
    bus.blk_in  = 24'h0C_0000;
    switch_once();
    check("blink_mode_en", 64'(bus.mode_en), 64'h8);
    for (int j = 0; j < 16; j++) begin
      tick();
      #3;
      check("blink_low", 64'(bus.seg[15:0]), (((j / 4) % 2) == 1) ? 64'hFFFF : 64'h0);
      check("blink_high", 64'(bus.seg[47:16]), 64'h0);
    end

    // randomized run with occasional mid-operation reset
    rand_disp();
    for (int c = 0; c < 1500; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      if ($urandom_range(0, 7) == 0) bus.mode_btn = ~bus.mode_btn;
      bus.norm_in = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
      if ($urandom_range(0, 3) == 0) bus.btn_in = 6'($urandom());
      if ($urandom_range(0, 15) == 0) rand_disp();
      if ($urandom_range(0, 15) == 0) bus.blk_in = 24'($urandom());
    end
    tick();
    rst_n = 1'b1;
    tick();
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
